ksz_bus_ctrl: RTL and testbench

//  Host-bus responder for the KSZ8851 16-bit parallel interface. Accepts register commands
//  (offset/length/WR/writeData/NewCommand) from the init and run-time sequencers and executes

---
 rtl/ksz_bus_ctrl_if.sv | 29 ++
 rtl/ksz_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_ksz_bus_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ksz_bus_ctrl_if.sv
// rtl/ksz_bus_ctrl_if.sv - command and chip-pin signal bundle for the KSZ8851 host-bus controller
`timescale 1ns/1ps
interface ksz_bus_ctrl_if;
    logic [7:0]  offset;
    logic        length;
    logic        WR;
    logic [15:0] writeData;
    logic        NewCommand;
    logic [3:0]  state;
    logic [15:0] readData;
    logic        readValid;
    logic        eth_csn;
    logic        eth_rdn;
    logic        eth_wrn;
    logic        eth_cmd;
    logic [15:0] sd_out;
    logic        sd_oe;
    logic [15:0] sd_in;

    modport slave (
        input  offset, length, WR, writeData, NewCommand, sd_in,
        output state, readData, readValid, eth_csn, eth_rdn, eth_wrn, eth_cmd, sd_out, sd_oe
    );

    modport master (
        output offset, length, WR, writeData, NewCommand, sd_in,
        input  state, readData, readValid, eth_csn, eth_rdn, eth_wrn, eth_cmd, sd_out, sd_oe
    );
endinterface

// File: rtl/ksz_bus_ctrl.sv
// rtl/ksz_bus_ctrl.sv - KSZ8851 16-bit parallel host-bus responder (address + data cycles)
`timescale 1ns/1ps
module ksz_bus_ctrl #(
    parameter int          STROBE_CYCLES = 1,
    parameter logic [15:0] IDLE_SD       = 16'h0000
) (
    input  logic            clk40m,
    input  logic            reset,
    ksz_bus_ctrl_if.slave   bus
);
    localparam logic [3:0] S_ADDR0  = 4'd0;
    localparam logic [3:0] S_ADDR1  = 4'd1;
    localparam logic [3:0] S_ADDR2  = 4'd2;
    localparam logic [3:0] S_READ0  = 4'd3;
    localparam logic [3:0] S_READ1  = 4'd4;
    localparam logic [3:0] S_READ2  = 4'd5;
    localparam logic [3:0] S_WRITE0 = 4'd6;
    localparam logic [3:0] S_WRITE1 = 4'd7;
    localparam logic [3:0] S_WRITE2 = 4'd8;
    localparam logic [3:0] S_WAIT   = 4'd9;

    localparam logic [1:0] STROBE_LAST = 2'(STROBE_CYCLES - 1);

    logic [3:0]  state_q, state_d;
    logic [1:0]  strobe_cnt_q, strobe_cnt_d;
    logic [7:0]  offset_q, offset_d;
    logic        length_q, length_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        csn, rdn, wrn, cmd, oe, rvalid;
    logic [15:0] sd;

    function automatic logic [15:0] cmd_word(input logic [7:0] off, input logic len);
        logic [3:0] be;
        if (len)
            be = off[1] ? 4'b1100 : 4'b0011;
        else
            be = 4'b0001 << off[1:0];
        return {4'b0000, be, off[7:2], 2'b00};
    endfunction

    always_ff @(posedge clk40m) begin
        if (reset) begin
            state_q      <= S_WAIT;
            strobe_cnt_q <= 2'd0;
            offset_q     <= 8'd0;
            length_q     <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= 16'd0;
            rdata_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            strobe_cnt_q <= strobe_cnt_d;
            offset_q     <= offset_d;
            length_q     <= length_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Command parameters are taken on the edge leaving Addr0, write data on the edge leaving Addr2,
    // so sequencers may still update them while those states are active.
    always_comb begin
        state_d      = state_q;
        strobe_cnt_d = 2'd0;
        offset_d     = offset_q;
        length_d     = length_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_WAIT:   if (bus.NewCommand) state_d = S_ADDR0;
            S_ADDR0: begin
                state_d  = S_ADDR1;
                offset_d = bus.offset;
                length_d = bus.length;
                wr_d     = bus.WR;
            end
            S_ADDR1:  state_d = S_ADDR2;
            S_ADDR2: begin
                state_d = wr_q ? S_WRITE0 : S_READ0;
                wdata_d = bus.writeData;
            end
            S_READ0, S_WRITE0: begin
                if (strobe_cnt_q == STROBE_LAST)
                    state_d = (state_q == S_READ0) ? S_READ1 : S_WRITE1;
                else
                    strobe_cnt_d = strobe_cnt_q + 2'd1;
            end
            S_READ1: begin
                state_d = S_READ2;
                rdata_d = bus.sd_in;
            end
            S_WRITE1: state_d = S_WRITE2;
            S_READ2, S_WRITE2: state_d = bus.NewCommand ? S_ADDR0 : S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        csn    = 1'b1;
        rdn    = 1'b1;
        wrn    = 1'b1;
        cmd    = 1'b0;
        oe     = 1'b0;
        rvalid = 1'b0;
        sd     = IDLE_SD;
        case (state_q)
            S_ADDR0: begin
                csn = 1'b0;
                cmd = 1'b1;
                oe  = 1'b1;
                sd  = cmd_word(bus.offset, bus.length);
            end
            S_ADDR1: begin
                csn = 1'b0;
                cmd = 1'b1;
                oe  = 1'b1;
                wrn = 1'b0;
                sd  = cmd_word(offset_q, length_q);
            end
            S_ADDR2: begin
                csn = 1'b0;
                cmd = 1'b1;
                oe  = 1'b1;
                sd  = cmd_word(offset_q, length_q);
            end
            S_READ0, S_READ1: begin
                csn = 1'b0;
                rdn = 1'b0;
            end
            S_READ2:  rvalid = 1'b1;
            S_WRITE0, S_WRITE1: begin
                csn = 1'b0;
                wrn = 1'b0;
                oe  = 1'b1;
                sd  = wdata_q;
            end
            S_WRITE2: begin
                oe = 1'b1;
                sd = wdata_q;
            end
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.readData  = rdata_q;
    assign bus.readValid = rvalid;
    assign bus.eth_csn   = csn;
    assign bus.eth_rdn   = rdn;
    assign bus.eth_wrn   = wrn;
    assign bus.eth_cmd   = cmd;
    assign bus.sd_out    = sd;
    assign bus.sd_oe     = oe;
endmodule

// File: tb/tb_ksz_bus_ctrl.sv
// tb/tb_ksz_bus_ctrl.sv - self-checking bench for ksz_bus_ctrl
`timescale 1ns/1ps
module tb_ksz_bus_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ksz_bus_ctrl_if bus_a();
    ksz_bus_ctrl_if bus_b();

    ksz_bus_ctrl #(.STROBE_CYCLES(1), .IDLE_SD(16'h0000)) dut_a (.clk40m(clk), .reset(rst), .bus(bus_a));
    ksz_bus_ctrl #(.STROBE_CYCLES(3), .IDLE_SD(16'hFFFF)) dut_b (.clk40m(clk), .reset(rst), .bus(bus_b));

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  off;
        logic        len;
        logic [15:0] wdata;
        logic [15:0] sdin;
        logic [15:0] exp_cmd;
        logic [15:0] exp_data;
        logic        b2b;
    } vec_t;

    typedef struct {
        logic [15:0] cmd;
        logic        wr;
        logic [15:0] data;
    } sb_t;

    vec_t vecs[6];
    sb_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: command word checked in Addr1, data checked in Read2/Write1.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.state == 4'd1) begin
                if (sb.size() == 0) chk("sb_empty_addr1", 32'd1, 32'd0);
                else begin
                    chk("cmd_word", 32'(bus_a.sd_out), 32'(sb[0].cmd));
                    chk("addr1_pins", 32'({bus_a.sd_oe, bus_a.eth_cmd, bus_a.eth_wrn, bus_a.eth_csn}), 32'b1100);
                end
            end
            if (bus_a.state == 4'd5) begin
                if (sb.size() == 0) chk("sb_empty_read", 32'd1, 32'd0);
                else begin
                    chk("read_kind", 32'(sb[0].wr), 32'd0);
                    chk("read_data", 32'({bus_a.readValid, bus_a.eth_rdn, bus_a.readData}), 32'({2'b11, sb[0].data}));
                    void'(sb.pop_front());
                end
            end
            if (bus_a.state == 4'd7) begin
                if (sb.size() == 0) chk("sb_empty_write", 32'd1, 32'd0);
                else begin
                    chk("write_kind", 32'(sb[0].wr), 32'd1);
                    chk("write_data", 32'({bus_a.sd_oe, bus_a.eth_wrn, bus_a.eth_rdn, bus_a.sd_out}), 32'({3'b101, sb[0].data}));
                    void'(sb.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if ((bus_a.sd_oe && !bus_a.eth_rdn) || (!bus_a.eth_rdn && !bus_a.eth_wrn)) viol++;
        if ((bus_b.sd_oe && !bus_b.eth_rdn) || (!bus_b.eth_rdn && !bus_b.eth_wrn)) viol++;
    end

    task automatic drive_a(input vec_t v);
        bus_a.WR        = v.wr;
        bus_a.offset    = v.off;
        bus_a.length    = v.len;
        bus_a.writeData = v.wdata;
        bus_a.sd_in     = v.sdin;
    endtask

    task automatic wait_a(input logic [3:0] s, input string name);
        int n = 0;
        while (bus_a.state !== s && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [27:0] trace;
        int rv_cnt, c3, c4, c6, c7;
        bit seen;

        vecs[0] = '{1'b0, 8'hC0, 1'b1, 16'h0000, 16'h8872, 16'h03C0, 16'h8872, 1'b0};
        vecs[1] = '{1'b1, 8'h12, 1'b1, 16'h4567, 16'h0000, 16'h0C10, 16'h4567, 1'b1};
        vecs[2] = '{1'b1, 8'h93, 1'b0, 16'h00AB, 16'h0000, 16'h0890, 16'h00AB, 1'b0};
        vecs[3] = '{1'b0, 8'h41, 1'b0, 16'h0000, 16'h1234, 16'h0240, 16'h1234, 1'b0};
        vecs[4] = '{1'b0, 8'hFE, 1'b1, 16'h0000, 16'hBEEF, 16'h0CFC, 16'hBEEF, 1'b0};
        vecs[5] = '{1'b1, 8'h06, 1'b0, 16'h5A5A, 16'h0000, 16'h0404, 16'h5A5A, 1'b0};

        rst = 1'b1;
        bus_a.WR = 1'b0; bus_a.offset = 8'h00; bus_a.length = 1'b0; bus_a.writeData = 16'h0;
        bus_a.NewCommand = 1'b0; bus_a.sd_in = 16'h0;
        bus_b.WR = 1'b0; bus_b.offset = 8'h00; bus_b.length = 1'b0; bus_b.writeData = 16'h0;
        bus_b.NewCommand = 1'b0; bus_b.sd_in = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_state", 32'(bus_a.state), 32'd9);
        chk("reset_read", 32'({bus_a.readValid, bus_a.readData}), 32'd0);
        chk("reset_pins", 32'({bus_a.eth_csn, bus_a.eth_rdn, bus_a.eth_wrn, bus_a.eth_cmd, bus_a.sd_oe}), 32'b11100);
        chk("reset_sd_a", 32'(bus_a.sd_out), 32'h0000);
        chk("reset_sd_b", 32'({bus_b.sd_oe, bus_b.sd_out}), 32'h0FFFF);

        // Single read: state trace and the combinational command word in Addr0.
        drive_a(vecs[0]);
        bus_a.NewCommand = 1'b1;
        sb.push_back('{16'h03C0, 1'b0, 16'h8872});
        trace = 28'h0;
        rv_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("addr0_word", 32'(bus_a.sd_out), 32'h03C0);
                chk("addr0_pins", 32'({bus_a.eth_cmd, bus_a.eth_csn, bus_a.eth_wrn, bus_a.sd_oe}), 32'b1011);
                bus_a.NewCommand = 1'b0;
            end
            trace = {trace[23:0], bus_a.state};
            if (bus_a.readValid) rv_cnt++;
        end
        chk("state_trace", 32'(trace), 32'h0123459);
        chk("readvalid_pulse", 32'(rv_cnt), 32'd1);

        for (int i = 0; i < 6; i++) begin
            drive_a(vecs[i]);
            bus_a.NewCommand = 1'b1;
            sb.push_back('{vecs[i].exp_cmd, vecs[i].wr, vecs[i].exp_data});
            wait_a(4'd0, "vec_addr0");
            if (!vecs[i].b2b) bus_a.NewCommand = 1'b0;
            wait_a(vecs[i].wr ? 4'd8 : 4'd5, "vec_end");
            @(negedge clk);
            if (vecs[i].b2b) chk("b2b_no_wait", 32'(bus_a.state), 32'd0);
        end

        // Read-modify-write: read F6, byte-swap into a back-to-back write.
        bus_a.WR = 1'b0; bus_a.offset = 8'hF6; bus_a.length = 1'b1; bus_a.sd_in = 16'h0020;
        bus_a.NewCommand = 1'b1;
        sb.push_back('{16'h0CF4, 1'b0, 16'h0020});
        wait_a(4'd5, "rmw_read");
        bus_a.WR = 1'b1;
        sb.push_back('{16'h0CF4, 1'b1, 16'h2000});
        @(negedge clk);
        chk("rmw_b2b", 32'(bus_a.state), 32'd0);
        chk("rmw_hold", 32'(bus_a.readData), 32'h0020);
        bus_a.writeData = 16'h2000;
        bus_a.NewCommand = 1'b0;
        wait_a(4'd8, "rmw_write");
        @(negedge clk);

        // Reset in the middle of Read1 aborts the access.
        bus_a.WR = 1'b0; bus_a.offset = 8'h10; bus_a.length = 1'b1; bus_a.sd_in = 16'hAAAA;
        bus_a.NewCommand = 1'b1;
        sb.push_back('{16'h0310, 1'b0, 16'hAAAA});
        wait_a(4'd0, "rst_addr0");
        bus_a.NewCommand = 1'b0;
        wait_a(4'd4, "rst_read1");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(bus_a.state), 32'd9);
        chk("rst_pins", 32'({bus_a.eth_csn, bus_a.eth_rdn, bus_a.eth_wrn, bus_a.sd_oe}), 32'b1110);
        chk("rst_read", 32'({bus_a.readValid, bus_a.readData}), 32'd0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);

        // Stretched strobes on the STROBE_CYCLES=3 instance.
        bus_b.WR = 1'b0; bus_b.offset = 8'h20; bus_b.length = 1'b1; bus_b.sd_in = 16'h1357;
        bus_b.NewCommand = 1'b1;
        c3 = 0; c4 = 0; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus_b.state == 4'd0) bus_b.NewCommand = 1'b0;
            if (bus_b.state == 4'd3) c3++;
            if (bus_b.state == 4'd4) c4++;
            if (bus_b.state == 4'd5) begin
                seen = 1'b1;
                chk("b_read_data", 32'({bus_b.readValid, bus_b.readData}), 32'h11357);
            end
        end
        if (!seen) chk("b_read_timeout", 32'd0, 32'd1);
        chk("b_read0_len", 32'(c3), 32'd3);
        chk("b_read1_len", 32'(c4), 32'd1);

        @(negedge clk);
        bus_b.WR = 1'b1; bus_b.offset = 8'h24; bus_b.writeData = 16'h9999;
        bus_b.NewCommand = 1'b1;
        c6 = 0; c7 = 0; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus_b.state == 4'd0) bus_b.NewCommand = 1'b0;
            if (bus_b.state == 4'd6) c6++;
            if (bus_b.state == 4'd7) begin
                c7++;
                chk("b_write_sd", 32'({bus_b.sd_oe, bus_b.sd_out}), 32'h19999);
            end
            if (bus_b.state == 4'd8) seen = 1'b1;
        end
        if (!seen) chk("b_write_timeout", 32'd0, 32'd1);
        chk("b_write0_len", 32'(c6), 32'd3);
        chk("b_write1_len", 32'(c7), 32'd1);
        @(negedge clk);

        chk("contention", 32'(viol), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
